// File: rtl/systolic_pkg.sv
// =============================================================================
// Module  : systolic_pkg
// Brief   : Shared types and constants for the 2x2 systolic operand feeder.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package systolic_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int WAVE_COUNT     = 4;

    typedef logic [1:0] wave_idx_t;

    localparam wave_idx_t LAST_WAVE = wave_idx_t'(WAVE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_gap_timer.sv
// =============================================================================
// Module  : systolic_gap_timer
// Brief   : Loadable down-counter; expire is high while the count is zero.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module systolic_gap_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             run,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

`default_nettype wire

// File: rtl/systolic_2x2_feeder.sv
// =============================================================================
// Module  : systolic_2x2_feeder
// Brief   : Captures 2x2 A/B operands and issues four skewed load waves to a
//           2x2 systolic array. Define FEEDER_DONE_HANDSHAKE_EN to pace waves
//           from done_in (with timeout/err) instead of the WAVE_GAP timer.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module systolic_2x2_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int WAVE_GAP       = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] a12,
    input  logic [DATA_W-1:0] a21,
    input  logic [DATA_W-1:0] a22,
    input  logic [DATA_W-1:0] b11,
    input  logic [DATA_W-1:0] b12,
    input  logic [DATA_W-1:0] b21,
    input  logic [DATA_W-1:0] b22,
    input  logic              done_in,
    output logic              load_in,
    output logic [DATA_W-1:0] row_out_row0,
    output logic [DATA_W-1:0] row_out_row1,
    output logic [DATA_W-1:0] col_out_col0,
    output logic [DATA_W-1:0] col_out_col1,
    output logic              busy,
    output logic              finished,
    output logic              err
);

`ifdef FEEDER_DONE_HANDSHAKE_EN
    localparam bit HANDSHAKE = 1'b1;
`else
    localparam bit HANDSHAKE = 1'b0;
`endif

    // One timer serves either the inter-wave gap or the handshake timeout.
    localparam int GAP_LIMIT = HANDSHAKE ? TIMEOUT_CYCLES : WAVE_GAP;
    localparam int CNT_W     = (GAP_LIMIT > 1) ? $clog2(GAP_LIMIT) : 1;
    localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_LIMIT - 1);

    localparam int OP_A11 = 0;
    localparam int OP_A12 = 1;
    localparam int OP_A21 = 2;
    localparam int OP_A22 = 3;
    localparam int OP_B11 = 4;
    localparam int OP_B12 = 5;
    localparam int OP_B21 = 6;
    localparam int OP_B22 = 7;

    feeder_state_t state;
    feeder_state_t state_nx;
    wave_idx_t     k;
    wave_idx_t     k_nx;

    logic [7:0][DATA_W-1:0] ops_in;
    logic [7:0][DATA_W-1:0] ops_q;
    logic [7:0][DATA_W-1:0] ops_src;
    logic [3:0][DATA_W-1:0] wave;

    logic timer_expire;
    logic wave_done;
    logic timed_out;
    logic abort;

    assign ops_in = {b22, b21, b12, b11, a22, a21, a12, a11};

    // Wave 0 is registered on the same edge that captures the operands,
    // so it must come straight from the inputs.
    assign ops_src = (state == IDLE) ? ops_in : ops_q;

    systolic_gap_timer #(
        .CNT_W (CNT_W)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (state == LOAD),
        .load_value (GAP_RELOAD),
        .run        (state == WAIT),
        .expire     (timer_expire)
    );

`ifdef FEEDER_DONE_HANDSHAKE_EN
    logic err_q;

    assign wave_done = done_in;
    assign timed_out = timer_expire && !done_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign err = err_q;
`else
    logic unused_done;

    assign unused_done = done_in;
    assign wave_done   = timer_expire;
    assign timed_out   = 1'b0;
    assign err         = 1'b0;
`endif

    assign abort = (state == WAIT) && !wave_done && timed_out;

    always_comb begin
        state_nx = state;
        k_nx     = k;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    k_nx     = '0;
                end
            end
            LOAD: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (wave_done) begin
                    if (k == LAST_WAVE) begin
                        state_nx = FINISH;
                    end else begin
                        state_nx = LOAD;
                        k_nx     = k + 2'd1;
                    end
                end else if (timed_out) begin
                    // Abort reuses the terminal cycle so busy drops one cycle after err.
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        wave = '0;
        case (k_nx)
            2'd0: begin
                wave[0] = ops_src[OP_A12];
                wave[2] = ops_src[OP_B21];
            end
            2'd1: begin
                wave[0] = ops_src[OP_A11];
                wave[1] = ops_src[OP_A22];
                wave[2] = ops_src[OP_B11];
                wave[3] = ops_src[OP_B22];
            end
            2'd2: begin
                wave[1] = ops_src[OP_A21];
                wave[3] = ops_src[OP_B12];
            end
            default: begin
                wave = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            ops_q        <= '0;
            load_in      <= 1'b0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            row_out_row0 <= '0;
            row_out_row1 <= '0;
            col_out_col0 <= '0;
            col_out_col1 <= '0;
        end else begin
            state    <= state_nx;
            k        <= k_nx;
            load_in  <= (state_nx == LOAD);
            busy     <= (state_nx != IDLE);
            finished <= (state_nx == FINISH) && !abort;
            if ((state == IDLE) && start) begin
                ops_q <= ops_in;
            end
            if (state_nx == LOAD) begin
                row_out_row0 <= wave[0];
                row_out_row1 <= wave[1];
                col_out_col0 <= wave[2];
                col_out_col1 <= wave[3];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_2x2_feeder.sv
// =============================================================================
// Module  : tb_systolic_2x2_feeder
// Brief   : Self-checking bench for systolic_2x2_feeder (either build).
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_systolic_2x2_feeder;

    localparam int DW  = 32;
    localparam int GAP = 20;
    localparam int TO  = 8;
`ifdef FEEDER_DONE_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          done_in;
    logic [DW-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic          load_in, busy, finished, err;
    logic [DW-1:0] row0, row1, col0, col1;

    always #5 clk = ~clk;

    systolic_2x2_feeder #(
        .DATA_W         (DW),
        .WAVE_GAP       (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a11          (a11),
        .a12          (a12),
        .a21          (a21),
        .a22          (a22),
        .b11          (b11),
        .b12          (b12),
        .b21          (b21),
        .b22          (b22),
        .done_in      (done_in),
        .load_in      (load_in),
        .row_out_row0 (row0),
        .row_out_row1 (row1),
        .col_out_col0 (col0),
        .col_out_col1 (col1),
        .busy         (busy),
        .finished     (finished),
        .err          (err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference: sequence active, wave index, cycles since that wave's load,
    // and the terminal cycle kind (1 = finished, 2 = timeout abort).
    bit            m_active = 1'b0;
    int            m_k      = 0;
    int            m_d      = 0;
    int            m_term   = 0;
    logic [DW-1:0] m_op[8];
    logic [DW-1:0] m_hold[4];

    int             load_log[$];
    int             fin_log[$];
    int             err_log[$];
    logic [127:0]   wave_log[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] wave_lane(input int k, input int lane);
        // m_op order: a11 a12 a21 a22 b11 b12 b21 b22; lanes row0 row1 col0 col1
        case (k)
            0: return (lane == 0) ? m_op[1] : (lane == 2) ? m_op[6] : '0;
            1: return (lane == 0) ? m_op[0] : (lane == 1) ? m_op[3] :
                      (lane == 2) ? m_op[4] : m_op[7];
            2: return (lane == 1) ? m_op[2] : (lane == 3) ? m_op[5] : '0;
            default: return '0;
        endcase
    endfunction

    task automatic load_hold();
        for (int l = 0; l < 4; l++) m_hold[l] = wave_lane(m_k, l);
    endtask

    task automatic tick();
        logic          p_rst, p_start, p_done;
        logic [DW-1:0] p_op[8];
        bit            exit_now, to_now;
        @(posedge clk);
        p_rst   = rst;
        p_start = start;
        p_done  = done_in;
        p_op    = '{a11, a12, a21, a22, b11, b12, b21, b22};
        #1;
        cyc++;
        if (p_rst) begin
            m_active = 1'b0; m_k = 0; m_d = 0; m_term = 0;
            for (int l = 0; l < 4; l++) m_hold[l] = '0;
        end else if (!m_active) begin
            if (p_start) begin
                m_active = 1'b1; m_k = 0; m_d = 0; m_term = 0;
                m_op = p_op;
                load_hold();
            end
        end else if (m_term != 0) begin
            m_active = 1'b0;
            m_term   = 0;
        end else begin
            if (HS) begin
                exit_now = (m_d >= 1) && p_done;
                to_now   = !exit_now && (m_d == TO);
            end else begin
                exit_now = (m_d == GAP);
                to_now   = 1'b0;
            end
            if (exit_now) begin
                if (m_k == 3) m_term = 1;
                else begin
                    m_k++; m_d = 0;
                    load_hold();
                end
            end else if (to_now) begin
                m_term = 2;
            end else begin
                m_d++;
            end
        end

        check("load_in",  load_in,  m_active && (m_term == 0) && (m_d == 0));
        check("busy",     busy,     m_active);
        check("finished", finished, m_term == 1);
        check("err",      err,      m_term == 2);
        check("row0",     row0,     m_hold[0]);
        check("row1",     row1,     m_hold[1]);
        check("col0",     col0,     m_hold[2]);
        check("col1",     col1,     m_hold[3]);

        if (load_in === 1'b1) begin
            load_log.push_back(cyc);
            wave_log.push_back({row0, row1, col0, col1});
        end
        if (finished === 1'b1) fin_log.push_back(cyc);
        if (err === 1'b1) err_log.push_back(cyc);
    endtask

    task automatic set_ops(input logic [DW-1:0] v[8]);
        {a11, a12, a21, a22} = {v[0], v[1], v[2], v[3]};
        {b11, b12, b21, b22} = {v[4], v[5], v[6], v[7]};
    endtask

    task automatic rand_ops();
        logic [DW-1:0] v[8];
        for (int i = 0; i < 8; i++) v[i] = $urandom;
        set_ops(v);
    endtask

    task automatic clear_logs();
        load_log.delete(); fin_log.delete(); err_log.delete(); wave_log.delete();
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            done_in = ($urandom_range(0, 3) == 0);
            tick();
        end
        done_in = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v[8];
        int            n;
        logic [127:0]  exp_wave[4];

        rst = 1'b1; start = 1'b0; done_in = 1'b0;
        for (int i = 0; i < 8; i++) v[i] = '0;
        set_ops(v);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Directed: A = B = [1 2; 3 4]
        v = '{1, 2, 3, 4, 1, 2, 3, 4};
        set_ops(v);
        clear_logs();
        start = 1'b1; n = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 95; i++) begin
            done_in = (load_log.size() > 0) && (cyc - load_log[$] == 5);
            tick();
        end
        done_in = 1'b0;
        exp_wave[0] = {32'd2, 32'd0, 32'd3, 32'd0};
        exp_wave[1] = {32'd1, 32'd4, 32'd1, 32'd4};
        exp_wave[2] = {32'd0, 32'd3, 32'd0, 32'd2};
        exp_wave[3] = '0;
        check("load_count", load_log.size(), 4);
        for (int i = 0; i < 4 && i < load_log.size(); i++) begin
            check("load_cycle", load_log[i] - n, HS ? 1 + 6 * i : 1 + i * (GAP + 1));
            check("wave_value", wave_log[i], exp_wave[i]);
        end
        check("fin_count", fin_log.size(), 1);
        if (fin_log.size() > 0)
            check("fin_cycle", fin_log[0] - n, HS ? 25 : 1 + 4 * (GAP + 1));

`ifdef FEEDER_DONE_HANDSHAKE_EN
        // Timeout with done_in held low
        rand_ops();
        clear_logs();
        start = 1'b1; n = cyc;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check("err_count", err_log.size(), 1);
        if (err_log.size() > 0) check("err_cycle", err_log[0] - n, 10);
        check("abort_fin", fin_log.size(), 0);

        // done_in during LOAD only is ignored
        rand_ops();
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        repeat (5) tick();
        check("load_done_ignored", load_log.size(), 1);
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
        check("done_advances", load_log.size(), 2);
        run_random(40);
`endif

        // start re-asserted while busy with changed operands
        rand_ops();
        start = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            rand_ops();
            start = ($urandom_range(0, 1) == 1);
            done_in = ($urandom_range(0, 3) == 0);
            tick();
        end
        start = 1'b0;
        run_random(HS ? 60 : 70);

        // Reset during the WAIT after wave 1
        rand_ops();
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && load_log.size() < 2; i++) begin
            done_in = ($urandom_range(0, 3) == 0);
            tick();
        end
        done_in = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_load", load_in, 1'b0);
        check("rst_data", {row0, row1, col0, col1}, 128'd0);
        rand_ops();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_load", load_in, 1'b1);
        check("restart_wave0", {row0, row1, col0, col1}, {a12, 32'd0, b21, 32'd0});
        run_random(100);

        // Random start/done traffic, including start held across FINISH
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) rand_ops();
            start   = ($urandom_range(0, 2) == 0);
            done_in = ($urandom_range(0, 4) == 0);
            tick();
        end
        start = 1'b0;
        done_in = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
